// File: rtl/rob_multiport.sv
// ============================================================================
// rob_multiport
// ----------------------------------------------------------------------------
// In-order reorder buffer with several independent writeback channels.
//
// Dispatch allocates an entry at the tail, and the entry index is the tag.
// Execution units return results by writing directly to that index on any of
// NUM_WB writeback channels, so no associative search is needed. Completed
// entries retire strictly in order from the head through a valid/ready
// commit port. A mispredict flush empties the whole buffer.
//
// Optional feature (macro ROB_PERF_CNT_EN):
//   Adds two free-running 32-bit performance counters, perf_commit_cnt and
//   perf_flush_cnt. When the macro is undefined, these ports and counters do
//   not exist, and core behaviour is unchanged.
//
// Ports:
//   clk_in          clock, rising edge
//   rst_in          asynchronous reset, active-low
//   rdy_in          global enable; 0 freezes all state
//   alloc_valid     dispatch requests an entry
//   alloc_ready     an entry is available (buffer not full)
//   alloc_addr      instruction address stored in the new entry
//   alloc_rd        destination register stored in the new entry
//   alloc_idx       index granted to the new entry (the current tail)
//   wb_valid        per-channel writeback strobes
//   wb_idx          packed target indices; channel k at [k*IDX_W +: IDX_W]
//   wb_val          packed result values; channel k at [k*DATA_W +: DATA_W]
//   flush           predict-fail clear
//   commit_valid    head entry is busy and done
//   commit_ready    consumer accepts the head entry
//   commit_idx      head index
//   commit_val      head result value (0 while commit_valid is low)
//   commit_addr     head instruction address (0 while commit_valid is low)
//   commit_rd       head destination register (0 while commit_valid is low)
//   count           number of occupied entries
//   empty           count == 0
//   perf_commit_cnt number of commits (ROB_PERF_CNT_EN only)
//   perf_flush_cnt  number of flush cycles (ROB_PERF_CNT_EN only)
// ============================================================================
module rob_multiport #(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int RD_W   = 5,
    parameter int NUM_WB = 2,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = IDX_W + 1
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     rdy_in,

    input  logic                     alloc_valid,
    output logic                     alloc_ready,
    input  logic [ADDR_W-1:0]        alloc_addr,
    input  logic [RD_W-1:0]          alloc_rd,
    output logic [IDX_W-1:0]         alloc_idx,

    input  logic [NUM_WB-1:0]        wb_valid,
    input  logic [NUM_WB*IDX_W-1:0]  wb_idx,
    input  logic [NUM_WB*DATA_W-1:0] wb_val,

    input  logic                     flush,

    output logic                     commit_valid,
    input  logic                     commit_ready,
    output logic [IDX_W-1:0]         commit_idx,
    output logic [DATA_W-1:0]        commit_val,
    output logic [ADDR_W-1:0]        commit_addr,
    output logic [RD_W-1:0]          commit_rd,

`ifdef ROB_PERF_CNT_EN
    output logic [31:0]              perf_commit_cnt,
    output logic [31:0]              perf_flush_cnt,
`endif

    output logic [CNT_W-1:0]         count,
    output logic                     empty
);

    // Occupancy value that means "every entry is in use".
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    // Per-entry storage
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  done_q;
    logic [DATA_W-1:0] val_q  [DEPTH];
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [RD_W-1:0]   rd_q   [DEPTH];

    // Ring pointers. DEPTH is a power of two, so the pointers wrap naturally.
    logic [IDX_W-1:0]  head_q;
    logic [IDX_W-1:0]  tail_q;
    logic [CNT_W-1:0]  count_q;

    // Per-entry writeback selection after channel arbitration
    logic [DEPTH-1:0]  wb_hit;
    logic [DATA_W-1:0] wb_data [DEPTH];

    logic alloc_fire;
    logic commit_fire;
    logic head_ready;

    // ------------------------------------------------------------------------
    // Handshakes and outputs. Every output depends only on registered state,
    // so there is no combinational path from an input to an output.
    //
    // Full is judged on the registered count. A commit in the same cycle
    // therefore cannot free a slot for that cycle's allocation.
    //
    // A flush suppresses both handshakes for its cycle, so a concurrent
    // alloc or commit is never treated as taken.
    // ------------------------------------------------------------------------
    assign head_ready   = busy_q[head_q] && done_q[head_q];

    assign alloc_ready  = (count_q != CNT_FULL);
    assign alloc_idx    = tail_q;

    assign commit_valid = head_ready;
    assign commit_idx   = head_q;
    assign commit_val   = head_ready ? val_q[head_q]  : '0;
    assign commit_addr  = head_ready ? addr_q[head_q] : '0;
    assign commit_rd    = head_ready ? rd_q[head_q]   : '0;

    assign count        = count_q;
    assign empty        = (count_q == '0);

    assign alloc_fire   = rdy_in && !flush && alloc_valid  && alloc_ready;
    assign commit_fire  = rdy_in && !flush && commit_ready && head_ready;

    // ------------------------------------------------------------------------
    // Writeback arbitration, resolved per entry. The channels are scanned
    // from highest to lowest, so when two channels target the same index in
    // one cycle, the lowest-numbered channel overrides the others and wins.
    // Whether the entry can actually accept the result (busy and not yet
    // done) is checked later, in the state update.
    // ------------------------------------------------------------------------
    always_comb begin
        wb_hit = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wb_data[i] = '0;
        end
        for (int i = 0; i < DEPTH; i++) begin
            for (int k = NUM_WB - 1; k >= 0; k--) begin
                if (wb_valid[k] && (wb_idx[k*IDX_W +: IDX_W] == IDX_W'(i))) begin
                    wb_hit[i]  = 1'b1;
                    wb_data[i] = wb_val[k*DATA_W +: DATA_W];
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Entry and pointer state.
    //
    // Writeback, alloc and commit never touch the same entry's flags in the
    // same cycle:
    //   - The tail entry is always idle while the buffer is not full, so a
    //     writeback there fails its busy check.
    //   - Commit needs done=1, while writeback needs done=0.
    // The flag updates are therefore order-independent.
    //
    // A writeback to the head lands this cycle. Because commit_valid comes
    // from the registered flags, that entry commits in a later cycle, never
    // in the writeback cycle itself.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            busy_q  <= '0;
            done_q  <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                val_q[i]  <= '0;
                addr_q[i] <= '0;
                rd_q[i]   <= '0;
            end
        end else if (rdy_in) begin
            if (flush) begin
                busy_q  <= '0;
                done_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                // Accept results only for in-flight entries that are not yet done.
                for (int i = 0; i < DEPTH; i++) begin
                    if (wb_hit[i] && busy_q[i] && !done_q[i]) begin
                        done_q[i] <= 1'b1;
                        val_q[i]  <= wb_data[i];
                    end
                end

                if (alloc_fire) begin
                    busy_q[tail_q] <= 1'b1;
                    done_q[tail_q] <= 1'b0;
                    val_q[tail_q]  <= '0;
                    addr_q[tail_q] <= alloc_addr;
                    rd_q[tail_q]   <= alloc_rd;
                    tail_q         <= tail_q + 1'b1;
                end

                if (commit_fire) begin
                    busy_q[head_q] <= 1'b0;
                    done_q[head_q] <= 1'b0;
                    head_q         <= head_q + 1'b1;
                end

                // Simultaneous alloc and commit leave the occupancy unchanged.
                if (alloc_fire && !commit_fire) begin
                    count_q <= count_q + 1'b1;
                end else if (commit_fire && !alloc_fire) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

`ifdef ROB_PERF_CNT_EN
    // ------------------------------------------------------------------------
    // Performance counters.
    //   - Both counters wrap naturally at 2^32 and freeze while rdy_in is low.
    //   - A flush does not clear them, so they accumulate across
    //     mispredictions.
    //   - commit_fire is already masked by flush, so a commit offered during
    //     a flush cycle is not counted.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            perf_commit_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else if (rdy_in) begin
            if (commit_fire) begin
                perf_commit_cnt <= perf_commit_cnt + 32'd1;
            end
            if (flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule
